rr_partition_gate: RTL and testbench
====================================

RR_PARTITION_GATE -- requirements
Module: rr_partition_gate

Interface
REQ-001 Parameters SHALL be: INPUT_SIZE, default 64, tuple payload width; NUM_IN, default 4, input channel count, range 2..16; ID, default 0, partition this gate accepts; SEL_LSB, default 0, lowest tag bit of the partition field; SEL_BITS, default 1, partition field width, range 1..8.
REQ-002 Ports SHALL be, in order:
  clk  in  1  sole clock, rising edge.
  resetn  in  1  asynchronous, active-low reset.
  in_ready  out  NUM_IN  per-channel accept.
  in_data  in  NUM_IN x INPUT_SIZE  packed payloads.
  in_tag  in  NUM_IN x 32  hash digests.
  in_valid  in  NUM_IN  per-channel valid.
  in_last_processed  in  NUM_IN  upstream channel drained.
  in_serialnum  in  NUM_IN x 64  tuple serial numbers.
  in_was_joined  in  NUM_IN  join flag.
  ready_4_output  in  1  downstream accept.
  out_data  out  INPUT_SIZE  payload.
  out_tag  out  32  digest.
  out_valid  out  1  output valid.
  out_serialnum  out  64  serial number.
  out_last_processed  out  1  all channels drained, sticky.
  out_was_joined  out  1  join flag.
  out_count  out  32  tuples forwarded since reset.

Function
REQ-003 Channel i SHALL request when in_valid[i]=1 and in_tag[i][SEL_LSB+SEL_BITS-1:SEL_LSB] equals ID[SEL_BITS-1:0].
REQ-004 Advance SHALL be defined as adv = ready_4_output | ~out_valid; all output registers and the state SHALL update only when adv=1, otherwise hold.
REQ-005 States SHALL be INIT, WORK, DONE; reset enters INIT; INIT->WORK unconditionally on the first adv cycle, producing no output.
REQ-006 In WORK with at least one request, the grant SHALL be the first requesting channel strictly after rr_ptr in ascending index order, wrapping from NUM_IN-1 to 0.
REQ-007 On a grant g with adv=1, out_* SHALL load channel g's data, tag, serialnum and was_joined, out_valid SHALL become 1, rr_ptr SHALL become g, and out_count SHALL increment by 1, wrapping from 2^32-1 to 0.
REQ-008 In WORK with no request, out_valid SHALL become 0 at the next adv edge, and rr_ptr and out_count SHALL hold.
REQ-009 in_ready[i] SHALL equal adv & ~(request_i & (i != grant)); non-requesting channels are thereby released for sibling gates, and losing requesters are back-pressured.
REQ-010 In INIT and DONE, in_ready[i] SHALL equal adv.
REQ-011 Latency SHALL be one cycle from an accepted input to out_valid; throughput SHALL be one tuple per cycle when ready_4_output=1.
REQ-012 WORK->DONE SHALL occur when, for every channel, in_valid=0 and in_last_processed=1, and out_valid is 0 or is being accepted in that cycle.
REQ-013 On entering DONE, out_last_processed SHALL become 1; it SHALL be cleared only by reset.
REQ-014 In DONE, out_valid SHALL be 0, and any in_valid that arrives SHALL be ignored.
REQ-015 A request coinciding with all-drained on another channel SHALL be served, and DONE SHALL NOT be entered in that cycle.
REQ-016 With a single requester, it SHALL be granted regardless of rr_ptr.
REQ-017 Combinational paths SHALL be limited to in_* -> in_ready and ready_4_output -> in_ready; all out_* SHALL be registered.

Reset
REQ-018 On resetn=0, asynchronously: state=INIT, rr_ptr=NUM_IN-1 (so channel 0 wins first), out_valid=0, out_data/out_tag/out_serialnum=0, out_was_joined=0, out_last_processed=0, out_count=0.
REQ-019 Reset asserted mid-stream SHALL discard the held output tuple without any handshake, and operation SHALL restart from INIT after release.
REQ-020 While resetn=0, in_ready SHALL be all-zero.

Verification
REQ-021 NUM_IN=4, ID=1, SEL_BITS=1: all channels valid with tag bit0=1 and ready held high -> outputs from channels 0,1,2,3,0 on consecutive cycles, with out_count=5.
REQ-022 Channel 2 tag bit0=0 and channel 3 matching -> in_ready[2]=1, channel 3 is forwarded, and channel 2's tuple never appears at the output.
REQ-023 ready_4_output=0 for 3 cycles with out_valid=1 -> out_* stable and in_ready all-zero, then the stream resumes with no loss or duplicate (check serialnums).
REQ-024 All channels drained with in_last_processed=1 while the output is held under stall -> out_last_processed rises only after the held tuple is accepted, and stays 1.
REQ-025 resetn pulsed low for 1 cycle mid-burst -> outputs are zero immediately (asynchronous), the first post-reset grant is channel 0, and out_count restarts at 1.
REQ-026 SEL_LSB=3, SEL_BITS=2, ID=2: tags 0x10, 0x18, 0x08 -> only 0x10 is forwarded.

Source files
------------

// File: rtl/rr_partition_gate.sv
// Round-robin partition gate.
// Accepts tuples only from channels whose tag partition field matches ID.
// Matching requesters are served round-robin into a single registered output stage.
// Non-matching channels are released so that sibling gates can take them.
// After every upstream channel reports drained, the gate enters a sticky done state.
module rr_partition_gate #(
    parameter int unsigned INPUT_SIZE = 64,
    parameter int unsigned NUM_IN     = 4,
    parameter int unsigned ID         = 0,
    parameter int unsigned SEL_LSB    = 0,
    parameter int unsigned SEL_BITS   = 1
) (
    input  logic                         clk,
    input  logic                         resetn,
    output logic [NUM_IN-1:0]            in_ready,
    input  logic [NUM_IN*INPUT_SIZE-1:0] in_data,
    input  logic [NUM_IN*32-1:0]         in_tag,
    input  logic [NUM_IN-1:0]            in_valid,
    input  logic [NUM_IN-1:0]            in_last_processed,
    input  logic [NUM_IN*64-1:0]         in_serialnum,
    input  logic [NUM_IN-1:0]            in_was_joined,
    input  logic                         ready_4_output,
    output logic [INPUT_SIZE-1:0]        out_data,
    output logic [31:0]                  out_tag,
    output logic                         out_valid,
    output logic [63:0]                  out_serialnum,
    output logic                         out_last_processed,
    output logic                         out_was_joined,
    output logic [31:0]                  out_count
);

    localparam int unsigned PtrW = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
    localparam logic [SEL_BITS-1:0] IdSel = SEL_BITS'(ID);
    localparam logic [PtrW-1:0] PtrReset = PtrW'(NUM_IN - 1);

    typedef enum logic [1:0] {
        StInit,
        StWork,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [PtrW-1:0]       rr_ptr_q, rr_ptr_d;
    logic                  out_valid_q, out_valid_d;
    logic [INPUT_SIZE-1:0] out_data_q, out_data_d;
    logic [31:0]           out_tag_q, out_tag_d;
    logic [63:0]           out_serial_q, out_serial_d;
    logic                  out_joined_q, out_joined_d;
    logic                  out_last_q, out_last_d;
    logic [31:0]           out_count_q, out_count_d;

    logic                  adv;
    logic [NUM_IN-1:0]     req;
    logic                  any_req;
    logic                  all_drained;
    logic [PtrW-1:0]       grant;
    logic [PtrW-1:0]       idx;

    logic [INPUT_SIZE-1:0] g_data;
    logic [31:0]           g_tag;
    logic [63:0]           g_serial;
    logic                  g_joined;

    // The output stage can move when it is empty or being drained downstream.
    assign adv = ready_4_output | ~out_valid_q;

    // Every channel has stopped offering tuples and has reported end of stream.
    assign all_drained = (in_valid == '0) && (&in_last_processed);

    // Per-channel request: valid tuple whose partition field selects this gate.
    always_comb begin
        req = '0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            req[i] = in_valid[i] && (in_tag[i*32 + int'(SEL_LSB) +: SEL_BITS] == IdSel);
        end
    end

    // Round-robin pick: the first requester strictly after rr_ptr, wrapping.
    // Scanning farthest-first and overwriting leaves the nearest requester as the winner.
    always_comb begin
        grant   = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int unsigned k = NUM_IN; k >= 1; k--) begin
            idx = PtrW'((32'(rr_ptr_q) + k) % NUM_IN);
            if (req[idx]) begin
                grant   = idx;
                any_req = 1'b1;
            end
        end
    end

    // Select the granted channel's payload fields.
    always_comb begin
        g_data   = '0;
        g_tag    = '0;
        g_serial = '0;
        g_joined = 1'b0;
        for (int i = 0; i < int'(NUM_IN); i++) begin
            if (grant == PtrW'(i)) begin
                g_data   = in_data[i*int'(INPUT_SIZE) +: INPUT_SIZE];
                g_tag    = in_tag[i*32 +: 32];
                g_serial = in_serialnum[i*64 +: 64];
                g_joined = in_was_joined[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= StInit;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: moves only on advance cycles.
    always_comb begin
        state_d = state_q;
        if (adv) begin
            unique case (state_q)
                StInit:  state_d = StWork;
                StWork:  if (!any_req && all_drained) state_d = StDone;
                StDone:  state_d = StDone;
                default: state_d = StInit;
            endcase
        end
    end

    // Ready outputs: only losing matching requesters are back-pressured.
    always_comb begin
        in_ready = '0;
        if (resetn) begin
            for (int i = 0; i < int'(NUM_IN); i++) begin
                in_ready[i] = adv;
                if (state_q == StWork && req[i] && grant != PtrW'(i)) begin
                    in_ready[i] = 1'b0;
                end
            end
        end
    end

    // Output stage and pointer next-state: hold unless advancing.
    always_comb begin
        rr_ptr_d     = rr_ptr_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_tag_d    = out_tag_q;
        out_serial_d = out_serial_q;
        out_joined_d = out_joined_q;
        out_last_d   = out_last_q;
        out_count_d  = out_count_q;
        if (adv) begin
            unique case (state_q)
                StInit: begin
                    out_valid_d = 1'b0;
                end
                StWork: begin
                    if (any_req) begin
                        out_valid_d  = 1'b1;
                        out_data_d   = g_data;
                        out_tag_d    = g_tag;
                        out_serial_d = g_serial;
                        out_joined_d = g_joined;
                        rr_ptr_d     = grant;
                        out_count_d  = out_count_q + 32'd1;
                    end else begin
                        out_valid_d = 1'b0;
                        // End-of-stream flag is sticky until reset.
                        if (all_drained) out_last_d = 1'b1;
                    end
                end
                StDone: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Output stage registers; reset discards any held tuple.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_q     <= PtrReset;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_tag_q    <= '0;
            out_serial_q <= '0;
            out_joined_q <= 1'b0;
            out_last_q   <= 1'b0;
            out_count_q  <= '0;
        end else begin
            rr_ptr_q     <= rr_ptr_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_tag_q    <= out_tag_d;
            out_serial_q <= out_serial_d;
            out_joined_q <= out_joined_d;
            out_last_q   <= out_last_d;
            out_count_q  <= out_count_d;
        end
    end

    assign out_valid          = out_valid_q;
    assign out_data           = out_data_q;
    assign out_tag            = out_tag_q;
    assign out_serialnum      = out_serial_q;
    assign out_was_joined     = out_joined_q;
    assign out_last_processed = out_last_q;
    assign out_count          = out_count_q;

endmodule

// File: tb/tb_rr_partition_gate.sv
// Directed bench for rr_partition_gate: a 4-channel ID=1 gate and a 2-bit field gate.
module tb_rr_partition_gate;

    logic clk;
    logic resetn;

    // Instance A: NUM_IN=4, ID=1, partition field = tag[0].
    logic [3:0]   a_ready;
    logic [63:0]  a_data;
    logic [127:0] a_tag;
    logic [3:0]   a_valid;
    logic [3:0]   a_last;
    logic [255:0] a_serial;
    logic [3:0]   a_joined;
    logic         a_rdy;
    logic [15:0]  a_out_data;
    logic [31:0]  a_out_tag;
    logic         a_out_valid;
    logic [63:0]  a_out_serial;
    logic         a_out_last;
    logic         a_out_joined;
    logic [31:0]  a_out_count;

    // Instance B: NUM_IN=4, ID=2, partition field = tag[4:3].
    logic [3:0]   b_ready;
    logic [63:0]  b_data;
    logic [127:0] b_tag;
    logic [3:0]   b_valid;
    logic [3:0]   b_last;
    logic [255:0] b_serial;
    logic [3:0]   b_joined;
    logic         b_rdy;
    logic [15:0]  b_out_data;
    logic [31:0]  b_out_tag;
    logic         b_out_valid;
    logic [63:0]  b_out_serial;
    logic         b_out_last;
    logic         b_out_joined;
    logic [31:0]  b_out_count;

    int errors = 0;
    int checks = 0;

    rr_partition_gate #(
        .INPUT_SIZE(16), .NUM_IN(4), .ID(1), .SEL_LSB(0), .SEL_BITS(1)
    ) u_dut_a (
        .clk(clk), .resetn(resetn), .in_ready(a_ready), .in_data(a_data), .in_tag(a_tag),
        .in_valid(a_valid), .in_last_processed(a_last), .in_serialnum(a_serial),
        .in_was_joined(a_joined), .ready_4_output(a_rdy), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_valid(a_out_valid), .out_serialnum(a_out_serial),
        .out_last_processed(a_out_last), .out_was_joined(a_out_joined),
        .out_count(a_out_count)
    );

    rr_partition_gate #(
        .INPUT_SIZE(16), .NUM_IN(4), .ID(2), .SEL_LSB(3), .SEL_BITS(2)
    ) u_dut_b (
        .clk(clk), .resetn(resetn), .in_ready(b_ready), .in_data(b_data), .in_tag(b_tag),
        .in_valid(b_valid), .in_last_processed(b_last), .in_serialnum(b_serial),
        .in_was_joined(b_joined), .ready_4_output(b_rdy), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_valid(b_out_valid), .out_serialnum(b_out_serial),
        .out_last_processed(b_out_last), .out_was_joined(b_out_joined),
        .out_count(b_out_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int ch, input logic v, input logic [31:0] tg,
                         input logic [15:0] d, input logic [63:0] sn, input logic j);
        a_valid[ch]           = v;
        a_tag[ch*32 +: 32]    = tg;
        a_data[ch*16 +: 16]   = d;
        a_serial[ch*64 +: 64] = sn;
        a_joined[ch]          = j;
    endtask

    task automatic set_b(input int ch, input logic v, input logic [31:0] tg,
                         input logic [15:0] d, input logic [63:0] sn);
        b_valid[ch]           = v;
        b_tag[ch*32 +: 32]    = tg;
        b_data[ch*16 +: 16]   = d;
        b_serial[ch*64 +: 64] = sn;
    endtask

    initial begin
        resetn = 1'b0;
        a_data = '0; a_tag = '0; a_valid = '0; a_last = '0; a_serial = '0; a_joined = '0;
        b_data = '0; b_tag = '0; b_valid = '0; b_last = '0; b_serial = '0; b_joined = '0;
        a_rdy = 1'b1;
        b_rdy = 1'b1;

        // Reset state.
        #2;
        chk("rst_in_ready", 64'(a_ready), 64'h0);
        chk("rst_out_valid", 64'(a_out_valid), 64'h0);
        chk("rst_out_count", 64'(a_out_count), 64'h0);
        chk("rst_out_last", 64'(a_out_last), 64'h0);
        chk("rst_out_data", 64'(a_out_data), 64'h0);
        tick();
        #2 resetn = 1'b1;
        #1;
        chk("init_in_ready", 64'(a_ready), 64'hF);
        tick();
        chk("init_no_output", 64'(a_out_valid), 64'h0);

        // Full round-robin: all channels match.
        for (int i = 0; i < 4; i++) begin
            set_a(i, 1'b1, 32'h1, 16'hA000 + 16'(i), 64'd100 + 64'(i), (i == 1));
        end
        #1;
        chk("rr_in_ready_first", 64'(a_ready), 64'h1);
        for (int n = 0; n < 5; n++) begin
            tick();
            chk("rr_data", 64'(a_out_data), 64'hA000 + 64'(n % 4));
            chk("rr_count", 64'(a_out_count), 64'(n + 1));
            chk("rr_joined", 64'(a_out_joined), 64'((n % 4) == 1));
            chk("rr_valid", 64'(a_out_valid), 64'h1);
        end
        chk("rr_tag", 64'(a_out_tag), 64'h1);
        chk("rr_in_ready_next", 64'(a_ready), 64'h2);

        // Channel 2 belongs to another partition; channel 3 matches.
        set_a(0, 1'b0, 32'h1, 16'hA000, 64'd100, 1'b0);
        set_a(1, 1'b0, 32'h1, 16'hA001, 64'd101, 1'b0);
        set_a(2, 1'b1, 32'h0, 16'hA002, 64'd102, 1'b0);
        set_a(3, 1'b1, 32'h1, 16'hA003, 64'd103, 1'b0);
        #1;
        chk("part_in_ready", 64'(a_ready), 64'hF);
        tick();
        chk("part_data", 64'(a_out_data), 64'hA003);
        chk("part_serial", 64'(a_out_serial), 64'd103);
        chk("part_count", 64'(a_out_count), 64'd6);
        tick();
        chk("single_req_data", 64'(a_out_data), 64'hA003);
        chk("single_req_count", 64'(a_out_count), 64'd7);

        // Downstream stall for three cycles.
        for (int i = 0; i < 4; i++) begin
            set_a(i, 1'b1, 32'h1, 16'hB000 + 16'(i), 64'd200 + 64'(i), 1'b0);
        end
        a_rdy = 1'b0;
        #1;
        chk("stall_in_ready", 64'(a_ready), 64'h0);
        for (int n = 0; n < 3; n++) begin
            tick();
            chk("stall_serial", 64'(a_out_serial), 64'd103);
            chk("stall_valid", 64'(a_out_valid), 64'h1);
            chk("stall_count", 64'(a_out_count), 64'd7);
            chk("stall_in_ready_hold", 64'(a_ready), 64'h0);
        end
        a_rdy = 1'b1;
        #1;
        chk("resume_in_ready", 64'(a_ready), 64'h1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("resume_serial", 64'(a_out_serial), 64'd200 + 64'(i));
            chk("resume_count", 64'(a_out_count), 64'd8 + 64'(i));
            set_a(i, 1'b0, 32'h1, 16'h0, 64'd0, 1'b0);
        end

        // Drained while the last tuple is held under stall.
        a_last = 4'hF;
        a_rdy  = 1'b0;
        #1;
        chk("drain_stall_ready", 64'(a_ready), 64'h0);
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("drain_hold_valid", 64'(a_out_valid), 64'h1);
            chk("drain_hold_serial", 64'(a_out_serial), 64'd203);
            chk("drain_hold_last", 64'(a_out_last), 64'h0);
        end
        a_rdy = 1'b1;
        #1;
        chk("drain_in_ready", 64'(a_ready), 64'hF);
        tick();
        chk("done_valid", 64'(a_out_valid), 64'h0);
        chk("done_last", 64'(a_out_last), 64'h1);
        chk("done_count", 64'(a_out_count), 64'd11);
        set_a(0, 1'b1, 32'h1, 16'hD000, 64'd400, 1'b0);
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("done_ignore_valid", 64'(a_out_valid), 64'h0);
            chk("done_sticky_last", 64'(a_out_last), 64'h1);
            chk("done_ignore_count", 64'(a_out_count), 64'd11);
            chk("done_in_ready", 64'(a_ready), 64'hF);
        end

        // Mid-burst asynchronous reset.
        a_valid = '0;
        a_last  = '0;
        resetn  = 1'b0;
        #2 resetn = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            set_a(i, 1'b1, 32'h1, 16'hC000 + 16'(i), 64'd300 + 64'(i), 1'b1);
        end
        tick();
        chk("burst_data0", 64'(a_out_data), 64'hC000);
        tick();
        chk("burst_data1", 64'(a_out_data), 64'hC001);
        chk("burst_count", 64'(a_out_count), 64'd2);
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 64'(a_out_valid), 64'h0);
        chk("arst_data", 64'(a_out_data), 64'h0);
        chk("arst_serial", 64'(a_out_serial), 64'h0);
        chk("arst_tag", 64'(a_out_tag), 64'h0);
        chk("arst_joined", 64'(a_out_joined), 64'h0);
        chk("arst_count", 64'(a_out_count), 64'h0);
        chk("arst_in_ready", 64'(a_ready), 64'h0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        chk("rerun_init_ready", 64'(a_ready), 64'hF);
        tick();
        chk("rerun_init_valid", 64'(a_out_valid), 64'h0);
        tick();
        chk("rerun_first_data", 64'(a_out_data), 64'hC000);
        chk("rerun_first_count", 64'(a_out_count), 64'd1);

        // Two-bit partition field at tag[4:3], ID=2.
        set_b(0, 1'b1, 32'h18, 16'hE000, 64'd500);
        set_b(1, 1'b1, 32'h10, 16'hE001, 64'd501);
        set_b(2, 1'b1, 32'h08, 16'hE002, 64'd502);
        #1;
        chk("sel_in_ready", 64'(b_ready), 64'hF);
        tick();
        chk("sel_data", 64'(b_out_data), 64'hE001);
        chk("sel_tag", 64'(b_out_tag), 64'h10);
        chk("sel_valid", 64'(b_out_valid), 64'h1);
        chk("sel_count", 64'(b_out_count), 64'd1);
        set_b(1, 1'b0, 32'h10, 16'hE001, 64'd501);
        for (int n = 0; n < 2; n++) begin
            tick();
            chk("sel_none_valid", 64'(b_out_valid), 64'h0);
            chk("sel_none_count", 64'(b_out_count), 64'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
